uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo_if.sv | 45 ++++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 91 +++++++++
 tb/tb_uart_tx_fifo.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit FIFO slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int BYTE_W = 8;

  // Drain state machine: wait for data, launch one byte, wait for Done, wait for Done to clear
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2,
    GAP  = 2'd3
  } drain_state_t;

  // Legal FIFO depth: a power of two between 2 and 256
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && (depth <= 256) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write side and transmitter side of the UART transmit FIFO.
// Latency: n/a (wiring only).
// Backpressure: producer sees o_Full/o_Count; writes while full are dropped. UART_TX_FIFO_OVF_EN adds o_Overflow.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              i_Wr_DV;
  logic [BYTE_W-1:0] i_Wr_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [CNT_W-1:0]  o_Count;
  logic              o_Tx_DV;
  logic [BYTE_W-1:0] o_Tx_Byte;
  logic              i_Tx_Active;
  logic              i_Tx_Done;

`ifdef UART_TX_FIFO_OVF_EN
  logic              o_Overflow;

  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte, o_Overflow
  );

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    output o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte, o_Overflow
  );
`else
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte
  );

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    output o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte
  );
`endif

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO with registered count and flags.
// Latency: an accepted write is readable at rd_dat from the next cycle.
// Backpressure: writes while full are ignored (no room made by a same-cycle pop); pops while empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   rd_vld,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Full is judged on the registered count, so a pop in the same cycle never admits a write
  assign wr_acc = wr_vld && !full;
  assign rd_acc = rd_vld && !empty;
  assign rd_dat = mem[rd_ptr];

  // Storage is deliberately left out of reset; only pointers decide what is valid
  always_ff @(posedge i_Clock) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally at DEPTH; count and flags move together so they always agree
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10: begin
          count <= count + CNT_ONE;
          empty <= 1'b0;
          full  <= (count == CNT_LAST);
        end
        2'b01: begin
          count <= count - CNT_ONE;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches one o_Tx_DV pulse per stored byte into a UART transmitter.
// Latency: a byte written into an empty FIFO (drain idle) pulses o_Tx_DV two cycles after its write strobe.
// Backpressure: none upstream, writes while full are dropped; define UART_TX_FIFO_OVF_EN for sticky o_Overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic           i_Clock,
  input logic           i_Rst_n,
  uart_tx_fifo_if.slave bus
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two in 2..256");
  end

  drain_state_t      state;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [BYTE_W-1:0] head;

  // The head byte leaves the FIFO on the edge that ends the launch cycle
  assign pop         = (state == SEND);
  assign bus.o_Full  = fifo_full;
  assign bus.o_Empty = fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .wr_vld  (bus.i_Wr_DV),
    .wr_dat  (bus.i_Wr_Byte),
    .rd_vld  (pop),
    .rd_dat  (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (bus.o_Count)
  );

  // Drain FSM: launch only into an idle transmitter, then wait out the whole Done pulse before relaunching
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= IDLE;
      bus.o_Tx_DV   <= 1'b0;
      bus.o_Tx_Byte <= '0;
    end else begin
      bus.o_Tx_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && !bus.i_Tx_Active && !bus.i_Tx_Done) begin
            state         <= SEND;
            bus.o_Tx_DV   <= 1'b1;
            bus.o_Tx_Byte <= head;
          end
        end
        SEND: begin
          state <= BUSY;
        end
        BUSY: begin
          if (bus.i_Tx_Done) begin
            state <= GAP;
          end
        end
        GAP: begin
          if (!bus.i_Tx_Done && !bus.i_Tx_Active) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky flag: remembers that at least one write arrived while the FIFO was full
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bus.o_Overflow <= 1'b0;
    end else if (bus.i_Wr_DV && fifo_full) begin
      bus.o_Overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus against a queue-based reference model.
// Latency: n/a.
// Backpressure: a transmitter model drives i_Tx_Active/i_Tx_Done with a two-cycle Done pulse.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] last_tx = 8'h00;
  logic       ovf_m = 1'b0;
  int         acc_total = 0;
  int         dv_total = 0;
  int         last_dv_cyc = -1;
  logic       dv_seen = 1'b0;
  logic       prev_dv = 1'b0;
  logic       tx_idle_edge = 1'b1;
  int         tx_clks = 4;
  int         tx_busy = 0;
  int         tx_done_left = 0;
  logic       tx_stall = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the FIFO is an ordered queue; full is judged before this edge's pop
  always @(posedge clk) begin : model
    bit was_full;
    if (!rst_n) begin
      q.delete();
      last_tx = 8'h00;
      ovf_m   = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      if (dv_seen && q.size() > 0) void'(q.pop_front());
      if (bus.i_Wr_DV) begin
        if (!was_full) begin
          q.push_back(bus.i_Wr_Byte);
          acc_total++;
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    chk("count", int'(bus.o_Count), q.size());
    chk("empty", int'(bus.o_Empty), int'(q.size() == 0));
    chk("full", int'(bus.o_Full), int'(q.size() == DEPTH));
`ifdef UART_TX_FIFO_OVF_EN
    chk("overflow", int'(bus.o_Overflow), int'(ovf_m));
`endif
    if (bus.o_Tx_DV === 1'b1) begin
      chk("dv_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("tx_byte_order", int'(bus.o_Tx_Byte), int'(q[0]));
        last_tx = q[0];
      end
      chk("dv_tx_idle", int'(tx_idle_edge), 1);
      chk("dv_single_cycle", int'(prev_dv), 0);
      got.push_back(bus.o_Tx_Byte);
      dv_total++;
      last_dv_cyc = cyc;
    end else begin
      chk("tx_byte_hold", int'(bus.o_Tx_Byte), int'(last_tx));
    end
    prev_dv = bus.o_Tx_DV;
    dv_seen = bus.o_Tx_DV;
  end

  // Transmitter model: busy tx_clks cycles per byte, then Done high for two cycles
  initial begin : tx_model
    bit launch;
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done   = 1'b0;
    forever begin
      @(posedge clk);
      tx_idle_edge = !bus.i_Tx_Active && !bus.i_Tx_Done;
      launch = dv_seen && rst_n;
      if (launch) chk("tx_overrun", int'(tx_busy == 0 && tx_done_left == 0), 1);
      #1;
      if (launch) begin
        tx_busy = tx_clks;
      end else if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) tx_done_left = 2;
      end else if (tx_done_left > 0) begin
        tx_done_left--;
      end
      bus.i_Tx_Active = tx_stall || (tx_busy > 0);
      bus.i_Tx_Done   = (tx_done_left > 0);
    end
  end

  task automatic cycle_wr(input logic v, input logic [7:0] b);
    bus.i_Wr_DV   = v;
    bus.i_Wr_Byte = b;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_wr(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tx_dv", int'(bus.o_Tx_DV), 0);
    chk("rst_count", int'(bus.o_Count), 0);
    chk("rst_empty", int'(bus.o_Empty), 1);
    chk("rst_full", int'(bus.o_Full), 0);
    chk("rst_tx_byte", int'(bus.o_Tx_Byte), 0);
    cycle_wr(1'b0, 8'h00);
    cycle_wr(1'b0, 8'h00);
    rst_n = 1'b1;
    cycle_wr(1'b0, 8'h00);
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while ((q.size() != 0 || tx_busy != 0 || tx_done_left != 0 || bus.o_Tx_DV) && i < budget) begin
      cycle_wr(1'b0, 8'h00);
      i++;
    end
    chk({name, "_drain_queue"}, q.size(), 0);
    chk({name, "_drain_empty"}, int'(bus.o_Empty), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dv0;
    int a0;
    int w;
    int k;
    int rate;
    bus.i_Wr_DV   = 1'b0;
    bus.i_Wr_Byte = 8'h00;
    @(negedge clk);
    #1;
    do_reset();

    // Single byte into an empty FIFO: one launch, two cycles after the write strobe
    tx_clks = 8;
    dv0 = dv_total;
    w = cyc;
    cycle_wr(1'b1, 8'hA5);
    drain("single", 200);
    chk("single_latency", last_dv_cyc, w + 2);
    chk("single_dv_count", dv_total - dv0, 1);
    chk("single_byte", int'(bus.o_Tx_Byte), 8'hA5);

    // Fill with the transmitter stalled, overflow by one, then drain in order
    tx_stall = 1'b1;
    for (int i = 0; i < 16; i++) cycle_wr(1'b1, 8'(i));
    chk("fill_full", int'(bus.o_Full), 1);
    chk("fill_count", int'(bus.o_Count), 16);
    cycle_wr(1'b1, 8'hFF);
    chk("drop_count", int'(bus.o_Count), 16);
`ifdef UART_TX_FIFO_OVF_EN
    chk("drop_overflow", int'(bus.o_Overflow), 1);
`endif
    got.delete();
    tx_stall = 1'b0;
    drain("fill", 1000);
    chk("fill_drained_n", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("fill_order", int'(got[i]), i);

    // Write on the same edge as a pop at count 5
    tx_stall = 1'b1;
    for (int i = 0; i < 5; i++) cycle_wr(1'b1, 8'h30 + 8'(i));
    tx_stall = 1'b0;
    k = 0;
    while (bus.o_Tx_DV !== 1'b1 && k < 50) begin
      cycle_wr(1'b0, 8'h00);
      k++;
    end
    chk("same_edge_launch", int'(bus.o_Tx_DV), 1);
    chk("same_edge_before", int'(bus.o_Count), 5);
    cycle_wr(1'b1, 8'h55);
    chk("same_edge_count", int'(bus.o_Count), 5);
    drain("same_edge", 1000);

    // Slow transmitter (87 clocks/bit, 10 bits), one write every 10 cycles: fills, then drops
    tx_clks = 870;
    for (int i = 0; i < 30; i++) begin
      cycle_wr(1'b1, 8'($urandom));
      idle(9);
    end
    drain("slow", 20000);

    // Reset while BUSY with 6 bytes queued
    tx_clks = 20;
    for (int i = 0; i < 7; i++) cycle_wr(1'b1, 8'h60 + 8'(i));
    chk("busy_queued", int'(bus.o_Count), 6);
    do_reset();
    dv0 = dv_total;
    idle(40);
    chk("post_reset_no_dv", dv_total - dv0, 0);
    cycle_wr(1'b1, 8'h3C);
    drain("post_reset", 200);
    chk("post_reset_dv", dv_total - dv0, 1);
    chk("post_reset_byte", int'(bus.o_Tx_Byte), 8'h3C);

    // Randomized traffic: every accepted byte launches exactly once
    dv0 = dv_total;
    a0 = acc_total;
    rate = 30;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) tx_stall = ~tx_stall;
      if ($urandom_range(0, 63) == 0) tx_clks = $urandom_range(1, 12);
      if ($urandom_range(0, 255) == 0) rate = $urandom_range(3, 60);
      cycle_wr($urandom_range(0, 99) < rate, 8'($urandom));
    end
    tx_stall = 1'b0;
    drain("random", 2000);
    chk("random_one_dv_per_byte", dv_total - dv0, acc_total - a0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
